// File: rtl/sample_avg_stage.sv
// Sequences the Sample ROM through one pass of addresses and runs each returned sample
// through a 2**LOG2_TAPS-tap moving-average filter, presented on a valid/ready output.
module sample_avg_stage #(
  parameter int NUM_SAMPLES = 1024,
  parameter int LOG2_TAPS   = 3,
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam int TAPS  = 2 ** LOG2_TAPS;
  localparam int SUM_W = DATA_W + LOG2_TAPS;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_SAMPLES - 1);

  typedef enum logic [2:0] {IDLE, FETCH, CAPT, OUT, DONE} state_t;

  state_t                   state, state_next;
  logic signed [DATA_W-1:0] taps [TAPS];
  logic signed [SUM_W-1:0]  sum, sum_next;
  logic [ADDR_W-1:0]        count;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = FETCH;
      FETCH:   state_next = CAPT;
      CAPT:    state_next = OUT;
      OUT:     if (out_ready) state_next = (count == LAST) ? DONE : FETCH;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // Running sum of the window: add the new sample, drop the one leaving the delay line.
  assign sum_next = sum + SUM_W'($signed(rom_data)) - SUM_W'(taps[TAPS-1]);

  always_ff @(posedge clk) begin
    if (reset) begin
      addr      <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      sum       <= '0;
      count     <= '0;
      for (int i = 0; i < TAPS; i++) taps[i] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            addr  <= '0;
            sum   <= '0;
            count <= '0;
            for (int i = 0; i < TAPS; i++) taps[i] <= '0;
          end
        end
        CAPT: begin
          taps[0] <= $signed(rom_data);
          for (int i = TAPS - 1; i > 0; i--) taps[i] <= taps[i-1];
          sum       <= sum_next;
          out_data  <= DATA_W'(sum_next >>> LOG2_TAPS);
          out_valid <= 1'b1;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            // addr tracks count, so it stops at the last sample instead of wrapping
            if (count != LAST) begin
              count <= count + 1'b1;
              addr  <= addr + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
